// File: rtl/mdu_ctrl_if.sv
// Pipeline <-> multiply/divide unit signal bundle.
// Master is the pipeline side, slave is the MDU.
interface mdu_ctrl_if;
    logic        E_en;
    logic [3:0]  E_mdu_op;
    logic [31:0] E_rs;
    logic [31:0] E_rt;
    logic        D_is_mdu;
    logic [31:0] E_rd_data;
    logic        busy;
    logic        mdu_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output E_en, E_mdu_op, E_rs, E_rt, D_is_mdu,
        input  E_rd_data, busy, mdu_stall, hi, lo
    );

    modport slave (
        input  E_en, E_mdu_op, E_rs, E_rt, D_is_mdu,
        output E_rd_data, busy, mdu_stall, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: fixed-latency MULT/DIV sequencing,
// HI/LO ownership and D-stage stall request.
module mdu_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input logic     clk,
    input logic     reset_n,
    mdu_ctrl_if.slave mdu
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES
                                                    : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t       state;
    logic [CW-1:0] cnt;
    logic [31:0]  hi_q;
    logic [31:0]  lo_q;
    logic [31:0]  pend_hi;
    logic [31:0]  pend_lo;
    logic         pend_skip;

    logic [3:0]   op;
    logic         is_mul;
    logic         is_div;
    logic         start;

    logic [63:0]  prod;
    logic         a_neg;
    logic         b_neg;
    logic [31:0]  a_mag;
    logic [31:0]  b_mag;
    logic [31:0]  b_safe;
    logic [31:0]  q_mag;
    logic [31:0]  r_mag;
    logic [31:0]  quot;
    logic [31:0]  rem;
    logic [31:0]  res_hi;
    logic [31:0]  res_lo;

    assign op     = mdu.E_mdu_op;
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign start  = mdu.E_en && (is_mul || is_div) && (state == IDLE);

    // Signed multiply via sign extension; low 64 bits are exact.
    always_comb begin
        prod = 64'd0;
        if (op == OP_MULT)
            prod = {{32{mdu.E_rs[31]}}, mdu.E_rs}
                 * {{32{mdu.E_rt[31]}}, mdu.E_rt};
        else
            prod = {32'd0, mdu.E_rs} * {32'd0, mdu.E_rt};
    end

    // Divide on magnitudes; 0x80000000/-1 falls out as lo=0x80000000.
    always_comb begin
        a_neg  = (op == OP_DIV) && mdu.E_rs[31];
        b_neg  = (op == OP_DIV) && mdu.E_rt[31];
        a_mag  = a_neg ? (~mdu.E_rs + 32'd1) : mdu.E_rs;
        b_mag  = b_neg ? (~mdu.E_rt + 32'd1) : mdu.E_rt;
        b_safe = (mdu.E_rt == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div) begin
            res_hi = rem;
            res_lo = quot;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi   <= 32'd0;
            pend_lo   <= 32'd0;
            pend_skip <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        pend_hi   <= res_hi;
                        pend_lo   <= res_lo;
                        pend_skip <= is_div && (mdu.E_rt == 32'd0);
                        cnt       <= is_mul ? CW'(MUL_CYCLES)
                                            : CW'(DIV_CYCLES);
                        state     <= BUSY;
                    end else if (mdu.E_en && op == OP_MTHI) begin
                        hi_q <= mdu.E_rs;
                    end else if (mdu.E_en && op == OP_MTLO) begin
                        lo_q <= mdu.E_rs;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                        if (!pend_skip) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mdu.E_rd_data = 32'd0;
        if (op == OP_MFHI)
            mdu.E_rd_data = hi_q;
        else if (op == OP_MFLO)
            mdu.E_rd_data = lo_q;
    end

    assign mdu.busy      = (state == BUSY);
    assign mdu.mdu_stall = mdu.D_is_mdu && (start || mdu.busy);
    assign mdu.hi        = hi_q;
    assign mdu.lo        = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: results, latency, stalls,
// MTHI/MTLO and asynchronous reset.
module tb_mdu_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    mdu_ctrl_if m ();

    mdu_ctrl #(
        .MUL_CYCLES(5),
        .DIV_CYCLES(10)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .mdu    (m)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in E for a single cycle, then count busy cycles.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int n);
        m.E_en = 1'b1;
        m.E_mdu_op = op;
        m.E_rs = a;
        m.E_rt = b;
        tick();
        m.E_en = 1'b0;
        m.E_mdu_op = 4'd0;
        n = 0;
        while (m.busy && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        m.E_en = 1'b0;
        m.E_mdu_op = 4'd0;
        m.E_rs = 32'd0;
        m.E_rt = 32'd0;
        m.D_is_mdu = 1'b0;
        reset_n = 1'b0;
        repeat (2) tick();
        total_cnt++;
        if (m.hi !== 32'd0 || m.lo !== 32'd0)
            $display("FAIL reset_hilo hi=%h lo=%h want 0/0", m.hi, m.lo);
        else pass_cnt++;
        total_cnt++;
        if (m.busy !== 1'b0 || m.mdu_stall !== 1'b0)
            $display("FAIL reset_flags busy=%b stall=%b want 0/0",
                     m.busy, m.mdu_stall);
        else pass_cnt++;
        total_cnt++;
        if (m.E_rd_data !== 32'd0)
            $display("FAIL reset_rd rd=%h want 0", m.E_rd_data);
        else pass_cnt++;
        reset_n = 1'b1;
        repeat (3) tick();
        total_cnt++;
        if (m.hi !== 32'd0 || m.lo !== 32'd0 || m.busy !== 1'b0)
            $display("FAIL reset_idle hi=%h lo=%h busy=%b want 0/0/0",
                     m.hi, m.lo, m.busy);
        else pass_cnt++;
    endtask

    task automatic test_mult();
        int n;
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, n);
        total_cnt++;
        if (n !== 5) $display("FAIL mult_lat got=%0d want 5", n);
        else pass_cnt++;
        total_cnt++;
        if (m.hi !== 32'hFFFF_FFFF || m.lo !== 32'hFFFF_FFFA)
            $display("FAIL mult_res hi=%h lo=%h want ffffffff/fffffffa",
                     m.hi, m.lo);
        else pass_cnt++;
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3, n);
        total_cnt++;
        if (n !== 5) $display("FAIL multu_lat got=%0d want 5", n);
        else pass_cnt++;
        total_cnt++;
        if (m.hi !== 32'h0000_0002 || m.lo !== 32'hFFFF_FFFA)
            $display("FAIL multu_res hi=%h lo=%h want 00000002/fffffffa",
                     m.hi, m.lo);
        else pass_cnt++;
    endtask

    task automatic test_div();
        int n;
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, n);
        total_cnt++;
        if (n !== 10) $display("FAIL div_lat got=%0d want 10", n);
        else pass_cnt++;
        total_cnt++;
        if (m.hi !== 32'hFFFF_FFFF || m.lo !== 32'hFFFF_FFFD)
            $display("FAIL div_res hi=%h lo=%h want ffffffff/fffffffd",
                     m.hi, m.lo);
        else pass_cnt++;
        run_op(4'd4, 32'd7, 32'd0, n);
        total_cnt++;
        if (n !== 10) $display("FAIL divz_lat got=%0d want 10", n);
        else pass_cnt++;
        total_cnt++;
        if (m.hi !== 32'hFFFF_FFFF || m.lo !== 32'hFFFF_FFFD)
            $display("FAIL divz_res hi=%h lo=%h want ffffffff/fffffffd",
                     m.hi, m.lo);
        else pass_cnt++;
        run_op(4'd4, 32'd100, 32'd7, n);
        total_cnt++;
        if (m.hi !== 32'd2 || m.lo !== 32'd14)
            $display("FAIL divu_res hi=%h lo=%h want 00000002/0000000e",
                     m.hi, m.lo);
        else pass_cnt++;
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        total_cnt++;
        if (m.hi !== 32'd0 || m.lo !== 32'h8000_0000)
            $display("FAIL div_ovf hi=%h lo=%h want 00000000/80000000",
                     m.hi, m.lo);
        else pass_cnt++;
    endtask

    task automatic test_hazard();
        int n;
        int bad;
        m.D_is_mdu = 1'b1;
        m.E_en = 1'b1;
        m.E_mdu_op = 4'd1;
        m.E_rs = 32'd6;
        m.E_rt = 32'd7;
        #1;
        total_cnt++;
        if (m.mdu_stall !== 1'b1)
            $display("FAIL stall_start got=%b want 1", m.mdu_stall);
        else pass_cnt++;
        tick();
        m.E_en = 1'b0;
        m.E_mdu_op = 4'd0;
        n = 0;
        bad = 0;
        while (m.busy && n < 40) begin
            if (m.mdu_stall !== 1'b1) bad++;
            n++;
            tick();
        end
        total_cnt++;
        if (bad !== 0 || n !== 5)
            $display("FAIL stall_busy missing=%0d cycles=%0d want 0/5",
                     bad, n);
        else pass_cnt++;
        total_cnt++;
        if (m.mdu_stall !== 1'b0)
            $display("FAIL stall_after got=%b want 0", m.mdu_stall);
        else pass_cnt++;
        total_cnt++;
        if (m.hi !== 32'd0 || m.lo !== 32'd42)
            $display("FAIL stall_res hi=%h lo=%h want 0/0000002a",
                     m.hi, m.lo);
        else pass_cnt++;
        m.D_is_mdu = 1'b0;
        m.E_en = 1'b1;
        m.E_mdu_op = 4'd1;
        #1;
        bad = (m.mdu_stall !== 1'b0) ? 1 : 0;
        tick();
        m.E_en = 1'b0;
        m.E_mdu_op = 4'd0;
        n = 0;
        while (m.busy && n < 40) begin
            if (m.mdu_stall !== 1'b0) bad++;
            n++;
            tick();
        end
        total_cnt++;
        if (bad !== 0)
            $display("FAIL nostall spurious=%0d want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_mt();
        int n;
        m.E_en = 1'b1;
        m.E_mdu_op = 4'd8;
        m.E_rs = 32'h1234_5678;
        tick();
        m.E_mdu_op = 4'd6;
        m.E_rs = 32'd0;
        #1;
        total_cnt++;
        if (m.E_rd_data !== 32'h1234_5678)
            $display("FAIL mflo rd=%h want 12345678", m.E_rd_data);
        else pass_cnt++;
        m.E_mdu_op = 4'd7;
        m.E_rs = 32'hCAFE_0001;
        tick();
        m.E_mdu_op = 4'd5;
        #1;
        total_cnt++;
        if (m.E_rd_data !== 32'hCAFE_0001)
            $display("FAIL mfhi rd=%h want cafe0001", m.E_rd_data);
        else pass_cnt++;
        m.E_en = 1'b0;
        m.E_mdu_op = 4'd7;
        m.E_rs = 32'h5555_5555;
        tick();
        total_cnt++;
        if (m.hi !== 32'hCAFE_0001)
            $display("FAIL en_gate hi=%h want cafe0001", m.hi);
        else pass_cnt++;
        m.E_en = 1'b1;
        m.E_mdu_op = 4'd1;
        m.E_rs = 32'hFFFF_FFFE;
        m.E_rt = 32'd3;
        tick();
        m.E_mdu_op = 4'd7;
        m.E_rs = 32'hDEAD_BEEF;
        tick();
        m.E_en = 1'b0;
        m.E_mdu_op = 4'd0;
        total_cnt++;
        if (m.hi !== 32'hCAFE_0001)
            $display("FAIL mthi_busy hi=%h want cafe0001", m.hi);
        else pass_cnt++;
        n = 0;
        while (m.busy && n < 40) begin
            n++;
            tick();
        end
        total_cnt++;
        if (m.hi !== 32'hFFFF_FFFF || m.lo !== 32'hFFFF_FFFA)
            $display("FAIL mthi_commit hi=%h lo=%h want ffffffff/fffffffa",
                     m.hi, m.lo);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        m.E_en = 1'b1;
        m.E_mdu_op = 4'd3;
        m.E_rs = 32'd100;
        m.E_rt = 32'd3;
        tick();
        m.E_en = 1'b0;
        m.E_mdu_op = 4'd0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (m.busy !== 1'b0 || m.hi !== 32'd0 || m.lo !== 32'd0)
            $display("FAIL rst_mid busy=%b hi=%h lo=%h want 0/0/0",
                     m.busy, m.hi, m.lo);
        else pass_cnt++;
        #10;
        reset_n = 1'b1;
        repeat (12) tick();
        total_cnt++;
        if (m.busy !== 1'b0 || m.hi !== 32'd0 || m.lo !== 32'd0)
            $display("FAIL rst_after busy=%b hi=%h lo=%h want 0/0/0",
                     m.busy, m.hi, m.lo);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_hazard();
        test_mt();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the five-stage pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the E stage and sequences a fixed-latency multi-cycle operation. It owns the HI/LO registers and raises a stall request to the hazard logic while any MDU instruction in D would collide with a busy unit.

## Interface
Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- E_en  in  1  E-stage instruction valid (not a bubble); gates all E-side actions
- E_mdu_op  in  4  op code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, others = NONE
- E_rs  in  32  forwarded rs value
- E_rt  in  32  forwarded rt value
- D_is_mdu  in  1  D-stage instruction is any MDU op (codes 1–8)
- E_rd_data  out  32  MFHI/MFLO read data (combinational)
- busy  out  1  operation in flight
- mdu_stall  out  1  stall request to D stage
- hi  out  32  current HI register
- lo  out  32  current LO register

## Operation
- State machine: IDLE, BUSY. Reset (asynchronous, reset_n=0): state IDLE, counter 0, hi=0, lo=0, pending results 0; busy=0, mdu_stall=0, E_rd_data=0.
- start = E_en && op∈{1..4} && state==IDLE. A start while BUSY is ignored (cannot occur with correct stalling).
- On start edge: result computed from E_rs/E_rt and latched into pending_hi/pending_lo; counter loaded with MUL_CYCLES or DIV_CYCLES; IDLE→BUSY.
- BUSY: counter decrements each edge; on the edge where counter==1, hi/lo ← pending, state→IDLE.
- MULT: {hi,lo} = signed 32×32→64 product. MULTU: unsigned 64-bit product.
- DIV: lo = signed quotient (truncated toward zero), hi = signed remainder (sign of dividend). DIVU: unsigned quotient/remainder.
- Divide by zero (E_rt==0): full DIV_CYCLES busy period; hi/lo unchanged at commit.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO: when E_en and state==IDLE, hi (or lo) ← E_rs at edge. Ignored while BUSY.
- E_rd_data = hi for MFHI, lo for MFLO, else 0; reflects register value, never pending value.
- mdu_stall = D_is_mdu && (start || busy).
- busy = (state==BUSY).

## Timing
- Start sampled at edge T0; busy high for exactly N cycles (T0+1 … T0+N), N = MUL_CYCLES or DIV_CYCLES.
- hi/lo show new result from the cycle after busy falls (edge T0+N).
- Back-to-back: a second MDU op in D stalls while start or busy; it enters E in the first cycle with busy=0 and sees committed hi/lo.
- Non-MDU instructions never stall here; the pipeline proceeds during BUSY.
- MTHI/MTLO take effect at the edge ending their E cycle; an MFHI in the next E cycle reads the new value.
- reset_n asserted mid-BUSY: immediately IDLE, busy=0, hi/lo=0, pending discarded; no commit after release.
- E_en=0 with a valid op code: no action.

## Test plan
- Reset: reset_n=0 for 2 cycles → hi=lo=0, busy=0, mdu_stall=0; release and idle 3 cycles, nothing changes.
- MULT E_rs=0xFFFFFFFE (−2), E_rt=3 → busy high 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV E_rs=0xFFFFFFF9 (−7), E_rt=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 → busy 10 cycles, hi/lo unchanged. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Hazard: MULT in E with D_is_mdu=1 → mdu_stall=1 in start cycle and all 5 busy cycles, 0 in first cycle after; D_is_mdu=0 throughout → mdu_stall stays 0.
- MTLO E_rs=0x12345678 while IDLE, then MFLO next cycle → E_rd_data=0x12345678; MTHI during BUSY → hi unaffected.
- reset_n pulsed low at busy cycle 3 of a DIV → busy drops immediately, hi=lo=0 and remain 0 after release.
